emoji_placement_ctrl: RTL and testbench

Edit-mode controller for the lens-filter emoji feature: it turns debounced button levels and the edit switch into a movable preview cursor and a bounded list of placed emojis. It sits directly upstream of `emoji_overlay` and drives all of its selector-side inputs. Cursor motion is applied only on frame ticks, so an emoji never moves mid-frame. The stored list is capped at 7 entries; a placement on a full list drops the oldest entry.

---
 rtl/emoji_pkg.sv | 18 +
 rtl/emoji_placement_ctrl_btn_rise.sv | 27 ++
 rtl/emoji_placement_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_emoji_placement_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/emoji_pkg.sv
// Shared constants and types for the emoji placement controller.
//   EMOJI_SIZE            sprite edge length in screen pixels
//   EMOJI_COUNT           number of emoji types
//   X_MAX / Y_MAX         largest cursor coordinate, in half-pixel units
//   CURSOR_X0 / CURSOR_Y0 cursor position after reset (screen centre)
//   place_state_t         controller mode
package emoji_pkg;

  localparam int unsigned EMOJI_SIZE  = 64;
  localparam int unsigned EMOJI_COUNT = 6;
  localparam int unsigned X_MAX       = 288;
  localparam int unsigned Y_MAX       = 208;
  localparam int unsigned CURSOR_X0   = 144;
  localparam int unsigned CURSOR_Y0   = 104;

  typedef enum logic [1:0] {VIEW, EDIT, CLEAR} place_state_t;

endpackage

// File: rtl/emoji_placement_ctrl_btn_rise.sv
// Rising-edge detector for a vector of debounced button levels.
//   clk   clock
//   reset synchronous active-low reset; clears the previous-value register
//   btn   current button levels
//   rise  btn & ~prev, one bit per button (combinational from btn)
module btn_rise #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= btn;
    end
  end

  assign rise = btn & ~prev_q;

endmodule

// File: rtl/emoji_placement_ctrl.sv
// Edit-mode controller for the emoji overlay: moves a preview cursor on frame ticks and keeps a
// bounded list of placed emojis (oldest in slot 0, oldest dropped when full).
//   clk, reset                       clock, synchronous active-low reset
//   frame_tick                       one-cycle pulse at start of vertical blanking
//   sw0_edit_mode                    edit switch level
//   btn_up/down/left/right           held levels, sampled on frame ticks
//   btn_place/type/clear             levels, act on rising edge
//   preview_enable                   cursor visible (EDIT only)
//   current_emoji_x/y/type           cursor position (half-pixel units) and type
//   emoji_count                      number of valid slots
//   emoji_x/y/type [0:MAX_EMOJI-1]   slot contents
// All outputs are registered.
module emoji_placement_ctrl #(
  parameter int unsigned MAX_EMOJI   = 8,
  parameter int unsigned EMOJI_COUNT = emoji_pkg::EMOJI_COUNT,
  parameter int unsigned STEP        = 2,
  parameter int unsigned X_MAX       = emoji_pkg::X_MAX,
  parameter int unsigned Y_MAX       = emoji_pkg::Y_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       sw0_edit_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_place,
  input  logic       btn_type,
  input  logic       btn_clear,
  output logic       preview_enable,
  output logic [8:0] current_emoji_x,
  output logic [8:0] current_emoji_y,
  output logic [2:0] current_emoji_type,
  output logic [2:0] emoji_count,
  output logic [8:0] emoji_x    [0:MAX_EMOJI-1],
  output logic [8:0] emoji_y    [0:MAX_EMOJI-1],
  output logic [2:0] emoji_type [0:MAX_EMOJI-1]
);

  // One slot is unusable because emoji_count is only 3 bits wide.
  localparam int unsigned CAP       = MAX_EMOJI - 1;
  localparam int unsigned IDX_W     = $clog2(MAX_EMOJI);
  localparam logic [2:0]  CNT_CAP   = 3'(CAP);
  localparam logic [2:0]  TYPE_LAST = 3'(EMOJI_COUNT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_EMOJI - 1);
  localparam logic [9:0]  STEP10    = 10'(STEP);
  localparam logic [8:0]  STEP9     = 9'(STEP);
  localparam logic [9:0]  XMAX10    = 10'(X_MAX);
  localparam logic [9:0]  YMAX10    = 10'(Y_MAX);

  emoji_pkg::place_state_t state_q, state_d;

  logic [2:0]       rise;
  logic             place_rise, type_rise, clear_rise;
  logic             do_clear, do_place, do_type, do_move, in_clear, preview_d;
  logic             preview_q;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic [8:0]       cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [2:0]       type_q, type_d, count_q, count_d;
  logic [9:0]       x_up, y_up;
  logic [8:0]       slot_x_q [0:MAX_EMOJI-1];
  logic [8:0]       slot_y_q [0:MAX_EMOJI-1];
  logic [2:0]       slot_t_q [0:MAX_EMOJI-1];
  logic [8:0]       slot_x_d [0:MAX_EMOJI-1];
  logic [8:0]       slot_y_d [0:MAX_EMOJI-1];
  logic [2:0]       slot_t_d [0:MAX_EMOJI-1];

  btn_rise #(
    .WIDTH(3)
  ) u_btn_rise (
    .clk  (clk),
    .reset(reset),
    .btn  ({btn_clear, btn_type, btn_place}),
    .rise (rise)
  );

  assign place_rise = rise[0];
  assign type_rise  = rise[1];
  assign clear_rise = rise[2];

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= emoji_pkg::VIEW;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: the edit switch going low wins from every state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      emoji_pkg::VIEW: if (sw0_edit_mode) state_d = emoji_pkg::EDIT;
      emoji_pkg::EDIT: begin
        if (!sw0_edit_mode)  state_d = emoji_pkg::VIEW;
        else if (clear_rise) state_d = emoji_pkg::CLEAR;
      end
      emoji_pkg::CLEAR: begin
        if (!sw0_edit_mode)              state_d = emoji_pkg::VIEW;
        else if (clr_idx_q == LAST_IDX) state_d = emoji_pkg::EDIT;
      end
      default: state_d = emoji_pkg::VIEW;
    endcase
  end

  // Action strobes; clear suppresses place and type in the same cycle.
  always_comb begin
    do_clear  = 1'b0;
    do_place  = 1'b0;
    do_type   = 1'b0;
    do_move   = 1'b0;
    in_clear  = (state_q == emoji_pkg::CLEAR);
    preview_d = (state_d == emoji_pkg::EDIT);
    if (state_q == emoji_pkg::EDIT && sw0_edit_mode) begin
      do_clear = clear_rise;
      do_place = place_rise & ~clear_rise;
      do_type  = type_rise & ~clear_rise;
      do_move  = frame_tick;
    end
  end

  // Cursor and type; placement reads the *_q values so it sees pre-move, pre-increment data.
  always_comb begin
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    type_d  = type_q;
    x_up    = {1'b0, cur_x_q} + STEP10;
    y_up    = {1'b0, cur_y_q} + STEP10;
    if (do_move && (btn_left ^ btn_right)) begin
      if (btn_right) cur_x_d = (x_up > XMAX10) ? XMAX10[8:0] : x_up[8:0];
      else           cur_x_d = (cur_x_q < STEP9) ? 9'd0 : cur_x_q - STEP9;
    end
    if (do_move && (btn_up ^ btn_down)) begin
      if (btn_down) cur_y_d = (y_up > YMAX10) ? YMAX10[8:0] : y_up[8:0];
      else          cur_y_d = (cur_y_q < STEP9) ? 9'd0 : cur_y_q - STEP9;
    end
    if (do_type) type_d = (type_q == TYPE_LAST) ? 3'd0 : type_q + 3'd1;
  end

  // Slot list
  always_comb begin
    slot_x_d  = slot_x_q;
    slot_y_d  = slot_y_q;
    slot_t_d  = slot_t_q;
    count_d   = count_q;
    clr_idx_d = in_clear ? clr_idx_q + 1'b1 : '0;
    if (in_clear) begin
      slot_x_d[clr_idx_q] = '0;
      slot_y_d[clr_idx_q] = '0;
      slot_t_d[clr_idx_q] = '0;
    end else if (do_clear) begin
      count_d = '0;
    end else if (do_place) begin
      if (count_q == CNT_CAP) begin
        // Full: drop the oldest and append at the top usable slot.
        for (int i = 0; i < int'(CAP) - 1; i++) begin
          slot_x_d[i] = slot_x_q[i+1];
          slot_y_d[i] = slot_y_q[i+1];
          slot_t_d[i] = slot_t_q[i+1];
        end
        slot_x_d[CAP-1] = cur_x_q;
        slot_y_d[CAP-1] = cur_y_q;
        slot_t_d[CAP-1] = type_q;
      end else begin
        slot_x_d[count_q] = cur_x_q;
        slot_y_d[count_q] = cur_y_q;
        slot_t_d[count_q] = type_q;
        count_d           = count_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      preview_q <= 1'b0;
      cur_x_q   <= 9'(emoji_pkg::CURSOR_X0);
      cur_y_q   <= 9'(emoji_pkg::CURSOR_Y0);
      type_q    <= '0;
      count_q   <= '0;
      clr_idx_q <= '0;
      for (int i = 0; i < int'(MAX_EMOJI); i++) begin
        slot_x_q[i] <= '0;
        slot_y_q[i] <= '0;
        slot_t_q[i] <= '0;
      end
    end else begin
      preview_q <= preview_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      type_q    <= type_d;
      count_q   <= count_d;
      clr_idx_q <= clr_idx_d;
      slot_x_q  <= slot_x_d;
      slot_y_q  <= slot_y_d;
      slot_t_q  <= slot_t_d;
    end
  end

  assign preview_enable     = preview_q;
  assign current_emoji_x    = cur_x_q;
  assign current_emoji_y    = cur_y_q;
  assign current_emoji_type = type_q;
  assign emoji_count        = count_q;
  assign emoji_x            = slot_x_q;
  assign emoji_y            = slot_y_q;
  assign emoji_type         = slot_t_q;

endmodule

// File: tb/tb_emoji_placement_ctrl.sv
module tb_emoji_placement_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0, sw0_edit_mode = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       btn_place = 1'b0, btn_type = 1'b0, btn_clear = 1'b0;
  logic       preview_enable;
  logic [8:0] cur_x, cur_y;
  logic [2:0] cur_t, count;
  logic [8:0] ex [0:7];
  logic [8:0] ey [0:7];
  logic [2:0] et [0:7];

  int errors = 0;
  int checks = 0;

  emoji_placement_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .frame_tick        (frame_tick),
    .sw0_edit_mode     (sw0_edit_mode),
    .btn_up            (btn_up),
    .btn_down          (btn_down),
    .btn_left          (btn_left),
    .btn_right         (btn_right),
    .btn_place         (btn_place),
    .btn_type          (btn_type),
    .btn_clear         (btn_clear),
    .preview_enable    (preview_enable),
    .current_emoji_x   (cur_x),
    .current_emoji_y   (cur_y),
    .current_emoji_type(cur_t),
    .emoji_count       (count),
    .emoji_x           (ex),
    .emoji_y           (ey),
    .emoji_type        (et)
  );

  always #5 clk = ~clk;

  // Inputs: {edit, up, down, left, right, place, type, clear, tick}
  typedef struct {
    logic [8:0] in;
    logic       pv;
    int         x, y, t, c;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(logic [8:0] in, logic pv, int x, int y, int t, int c);
    vec_t v;
    v.in = in; v.pv = pv; v.x = x; v.y = y; v.t = t; v.c = c;
    return v;
  endfunction

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    frame_tick = 0; sw0_edit_mode = 0;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    btn_place = 0; btn_type = 0; btn_clear = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    step();
    step();
    reset = 1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1; step();
      frame_tick = 0; step();
    end
  endtask

  task automatic place_pulse();
    btn_place = 1; step();
    btn_place = 0; step();
  endtask

  task automatic enter_edit();
    sw0_edit_mode = 1;
    step();
  endtask

  initial begin
    vecs[0]  = mk(9'b1_0000_0000, 1, 144, 104, 0, 0);
    vecs[1]  = mk(9'b1_0000_0100, 1, 144, 104, 1, 0);
    vecs[2]  = mk(9'b1_0000_0000, 1, 144, 104, 1, 0);
    vecs[3]  = mk(9'b1_0000_0100, 1, 144, 104, 2, 0);
    vecs[4]  = mk(9'b1_0000_0000, 1, 144, 104, 2, 0);
    vecs[5]  = mk(9'b1_0000_0100, 1, 144, 104, 3, 0);
    vecs[6]  = mk(9'b1_0000_0100, 1, 144, 104, 3, 0);  // held: no re-fire
    vecs[7]  = mk(9'b1_0001_0001, 1, 146, 104, 3, 0);  // right + tick
    vecs[8]  = mk(9'b1_0001_0000, 1, 146, 104, 3, 0);  // right, no tick
    vecs[9]  = mk(9'b1_0011_0001, 1, 146, 104, 3, 0);  // left+right
    vecs[10] = mk(9'b1_1000_0001, 1, 146, 102, 3, 0);  // up
    vecs[11] = mk(9'b1_1100_0001, 1, 146, 102, 3, 0);  // up+down
    vecs[12] = mk(9'b1_0110_0001, 1, 144, 104, 3, 0);  // down+left
    vecs[13] = mk(9'b1_0000_1000, 1, 144, 104, 3, 1);  // place
    vecs[14] = mk(9'b1_0000_0000, 1, 144, 104, 3, 1);
    vecs[15] = mk(9'b1_0000_1100, 1, 144, 104, 4, 2);  // place + type
    vecs[16] = mk(9'b1_0000_0000, 1, 144, 104, 4, 2);
    vecs[17] = mk(9'b1_0000_0100, 1, 144, 104, 5, 2);
    vecs[18] = mk(9'b1_0000_0000, 1, 144, 104, 5, 2);
    vecs[19] = mk(9'b1_0000_0100, 1, 144, 104, 0, 2);  // type wraps
    vecs[20] = mk(9'b1_0001_1001, 1, 146, 104, 0, 3);  // place + move
    vecs[21] = mk(9'b0_0001_0001, 0, 146, 104, 0, 3);  // leave edit
    vecs[22] = mk(9'b0_0000_0100, 0, 146, 104, 0, 3);  // ignored in VIEW
    vecs[23] = mk(9'b1_0000_0100, 1, 146, 104, 0, 3);
    vecs[24] = mk(9'b1_0000_0000, 1, 146, 104, 0, 3);
    vecs[25] = mk(9'b1_0000_0100, 1, 146, 104, 1, 3);

    // Reset values
    step();
    step();
    chk("rst_preview", int'(preview_enable), 0);
    chk("rst_x", int'(cur_x), 144);
    chk("rst_y", int'(cur_y), 104);
    chk("rst_type", int'(cur_t), 0);
    chk("rst_count", int'(count), 0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_slot%0d", i), int'(ex[i] | ey[i] | 9'(et[i])), 0);
    reset = 1;

    // Table-driven per-cycle vectors
    for (int i = 0; i < 26; i++) begin
      {sw0_edit_mode, btn_up, btn_down, btn_left, btn_right,
       btn_place, btn_type, btn_clear, frame_tick} = vecs[i].in;
      step();
      chk($sformatf("v%0d_preview", i), int'(preview_enable), int'(vecs[i].pv));
      chk($sformatf("v%0d_x", i), int'(cur_x), vecs[i].x);
      chk($sformatf("v%0d_y", i), int'(cur_y), vecs[i].y);
      chk($sformatf("v%0d_type", i), int'(cur_t), vecs[i].t);
      chk($sformatf("v%0d_count", i), int'(count), vecs[i].c);
    end
    chk("tbl_slot0_x", int'(ex[0]), 144);
    chk("tbl_slot0_y", int'(ey[0]), 104);
    chk("tbl_slot0_t", int'(et[0]), 3);
    chk("tbl_slot1_t", int'(et[1]), 3);
    chk("tbl_slot2_x", int'(ex[2]), 144);
    chk("tbl_slot2_t", int'(et[2]), 0);
    chk("tbl_slot3_x", int'(ex[3]), 0);

    // Cursor saturation at all four edges
    clear_inputs();
    do_reset();
    enter_edit();
    btn_right = 1;
    ticks(10);
    chk("sat_x_10", int'(cur_x), 164);
    ticks(190);
    chk("sat_x_max", int'(cur_x), 288);
    btn_right = 0; btn_left = 1;
    ticks(200);
    chk("sat_x_min", int'(cur_x), 0);
    btn_left = 0; btn_up = 1;
    ticks(60);
    chk("sat_y_min", int'(cur_y), 0);
    btn_up = 0; btn_down = 1;
    ticks(120);
    chk("sat_y_max", int'(cur_y), 208);
    btn_down = 0;

    // Nine placements at x = 10*n: oldest entries are dropped
    clear_inputs();
    do_reset();
    enter_edit();
    btn_left = 1;
    ticks(72);
    btn_left = 0;
    chk("fill_x0", int'(cur_x), 0);
    for (int n = 0; n < 9; n++) begin
      place_pulse();
      chk($sformatf("fill_count%0d", n), int'(count), (n + 1 > 7) ? 7 : n + 1);
      btn_right = 1;
      ticks(5);
      btn_right = 0;
    end
    for (int i = 0; i < 7; i++) chk($sformatf("fill_slot%0d_x", i), int'(ex[i]), 20 + 10 * i);
    chk("fill_slot7_x", int'(ex[7]), 0);

    // Clear and place rising together; buttons during CLEAR are dropped
    clear_inputs();
    do_reset();
    enter_edit();
    place_pulse();
    place_pulse();
    place_pulse();
    chk("clr_pre_count", int'(count), 3);
    btn_clear = 1; btn_place = 1;
    step();
    chk("clr_entry_count", int'(count), 0);
    chk("clr_entry_preview", int'(preview_enable), 0);
    btn_clear = 0;
    step();
    step();
    btn_type = 1;
    for (int i = 0; i < 5; i++) step();
    chk("clr_len7_preview", int'(preview_enable), 0);
    step();
    chk("clr_len8_preview", int'(preview_enable), 1);
    step();
    chk("clr_after_count", int'(count), 0);
    chk("clr_after_type", int'(cur_t), 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("clr_slot%0d_x", i), int'(ex[i]), 0);
      chk($sformatf("clr_slot%0d_y", i), int'(ey[i]), 0);
      chk($sformatf("clr_slot%0d_t", i), int'(et[i]), 0);
    end

    // Edit switch dropped mid-CLEAR, then reset mid-CLEAR
    clear_inputs();
    do_reset();
    enter_edit();
    btn_right = 1;
    ticks(3);
    btn_right = 0;
    place_pulse();
    place_pulse();
    btn_clear = 1; step();
    btn_clear = 0; step();
    step();
    sw0_edit_mode = 0;
    step();
    chk("abort_preview", int'(preview_enable), 0);
    sw0_edit_mode = 1;
    step();
    chk("abort_back_to_edit", int'(preview_enable), 1);
    chk("abort_x_kept", int'(cur_x), 150);
    chk("abort_count", int'(count), 0);
    place_pulse();
    chk("abort_place_ok", int'(count), 1);
    btn_clear = 1; step();
    btn_clear = 0; step();
    reset = 0;
    step();
    chk("rstclr_x", int'(cur_x), 144);
    chk("rstclr_count", int'(count), 0);
    chk("rstclr_slot0", int'(ex[0]), 0);
    chk("rstclr_preview", int'(preview_enable), 0);
    reset = 1;

    // btn_type held across reset must not fire after release
    clear_inputs();
    do_reset();
    enter_edit();
    btn_type = 1; step();
    btn_type = 0; step();
    btn_type = 1; step();
    chk("hold_pre_type", int'(cur_t), 2);
    reset = 0;
    step();
    step();
    chk("hold_in_rst_type", int'(cur_t), 0);
    reset = 1;
    step();
    step();
    step();
    chk("hold_after_rst_type", int'(cur_t), 0);
    btn_type = 0; step();
    btn_type = 1; step();
    chk("hold_new_rise_type", int'(cur_t), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
